// File: rtl/logic_gate_pkg.sv
// Shared types for the registered bitwise logic unit.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_BUFA = 3'd7
    } op_e;

    localparam op_e OP_DEFAULT = OP_AND;

endpackage

// File: rtl/logic_gate_alu.sv
// Combinational bitwise operator: eight Boolean functions of a and b.
module logic_gate_alu
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op_e'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            OP_BUFA: y = a;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered logic unit: one-cycle bitwise op with valid and zero/ones flags.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [2:0]       op_sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             result_zero,
    output logic             result_ones
);

    logic [WIDTH-1:0] alu_y;

    logic_gate_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a (input_a),
        .b (input_b),
        .op(op_sel),
        .y (alu_y)
    );

    // Flags derive from the value being captured, so they always track result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result      <= '0;
            out_valid   <= 1'b0;
            result_zero <= 1'b1;
            result_ones <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result      <= alu_y;
                result_zero <= ~|alu_y;
                result_ones <= &alu_y;
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit at WIDTH=4 and WIDTH=1.
module tb_logic_gate_unit;

    logic       clk;
    logic       rst_n;

    logic [3:0] a4, b4, r4;
    logic [2:0] op4;
    logic       v4, ov4, z4, o4;

    logic       a1, b1, r1;
    logic [2:0] op1;
    logic       v1, ov1, z1, o1;

    typedef struct {
        logic [3:0] r;
        logic       z;
        logic       o;
        string      tag;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [3:0] ALL_EXP [8] = '{
        4'b1000, 4'b1110, 4'b0110, 4'b0111,
        4'b0001, 4'b1001, 4'b0011, 4'b1100
    };

    logic_gate_unit #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .input_a    (a4),
        .input_b    (b4),
        .op_sel     (op4),
        .in_valid   (v4),
        .result     (r4),
        .out_valid  (ov4),
        .result_zero(z4),
        .result_ones(o4)
    );

    logic_gate_unit #(.WIDTH(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .input_a    (a1),
        .input_b    (b1),
        .op_sel     (op1),
        .in_valid   (v1),
        .result     (r1),
        .out_valid  (ov1),
        .result_zero(z1),
        .result_ones(o1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [3:0] model(input logic [2:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    task automatic drive4(input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] r,
                          input string tag);
        exp_t e;
        op4 = op;
        a4  = a;
        b4  = b;
        v4  = 1'b1;
        e.r   = r;
        e.z   = (r == 4'h0);
        e.o   = (r == 4'hf);
        e.tag = tag;
        q4.push_back(e);
    endtask

    task automatic issue4(input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] r,
                          input string tag);
        @(negedge clk);
        drive4(op, a, b, r, tag);
    endtask

    task automatic issue1(input logic a, input logic b, input logic r,
                          input string tag);
        exp_t e;
        @(negedge clk);
        op1 = 3'd0;
        a1  = a;
        b1  = b;
        v1  = 1'b1;
        e.r   = {3'b000, r};
        e.z   = (r == 1'b0);
        e.o   = (r == 1'b1);
        e.tag = tag;
        q1.push_back(e);
    endtask

    task automatic idle4();
        @(negedge clk);
        v4 = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_r4"}, r4, 0);
        check({tag, "_ov4"}, ov4, 0);
        check({tag, "_z4"}, z4, 1);
        check({tag, "_o4"}, o4, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && ov4) begin
            if (q4.size() == 0) begin
                check("sb4_unexpected", 1, 0);
            end else begin
                e4 = q4.pop_front();
                check({e4.tag, "_res"}, r4, e4.r);
                check({e4.tag, "_zero"}, z4, e4.z);
                check({e4.tag, "_ones"}, o4, e4.o);
            end
        end
        if (rst_n && ov1) begin
            if (q1.size() == 0) begin
                check("sb1_unexpected", 1, 0);
            end else begin
                e1 = q1.pop_front();
                check({e1.tag, "_res"}, r1, e1.r);
                check({e1.tag, "_zero"}, z1, e1.z);
                check({e1.tag, "_ones"}, o1, e1.o);
            end
        end
    end

    initial begin
        logic [2:0] rop;
        logic [3:0] ra, rb;

        rst_n = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); op4 = 3'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); op1 = 3'($urandom);
        v4 = 1'b1;
        v1 = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst_hold");
        check("rst_hold_r1", r1, 0);
        check("rst_hold_ov1", ov1, 0);
        check("rst_hold_z1", z1, 1);
        check("rst_hold_o1", o1, 0);

        rst_n = 1'b1;
        v4 = 1'b0;
        v1 = 1'b0;

        issue1(1'b1, 1'b1, 1'b1, "w1_and11");
        issue1(1'b0, 1'b1, 1'b0, "w1_and01");
        @(negedge clk);
        v1 = 1'b0;

        for (int i = 0; i < 8; i++)
            issue4(3'(i), 4'b1100, 4'b1010, ALL_EXP[i], $sformatf("op%0d", i));
        issue4(3'd0, 4'b0000, 4'b1111, 4'b0000, "and_zero");
        issue4(3'd1, 4'b1010, 4'b0101, 4'b1111, "or_ones");

        issue4(3'd1, 4'b0011, 4'b0100, 4'b0111, "hold_or");
        @(negedge clk);
        v4 = 1'b0;
        a4 = 4'b0000;
        b4 = 4'b0000;
        op4 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a4 = 4'($urandom);
            check("hold_ov", ov4, 0);
            check("hold_res", r4, 4'b0111);
            check("hold_zero", z4, 0);
        end

        for (int i = 0; i < 8; i++) begin
            rop = 3'(i ^ 5);
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            issue4(rop, ra, rb, model(rop, ra, rb), $sformatf("b2b%0d", i));
            if (i > 0) check("b2b_valid", ov4, 1);
        end
        idle4();
        check("b2b_last_valid", ov4, 1);

        issue4(3'd2, 4'b1111, 4'b0001, 4'b1110, "pre_rst0");
        issue4(3'd0, 4'b1111, 4'b1111, 4'b1111, "pre_rst1");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_async");
        q4.delete();
        @(negedge clk);
        check_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        drive4(3'd2, 4'b1100, 4'b0101, 4'b1001, "post_rst");
        @(negedge clk);
        check("post_rst_valid", ov4, 1);
        v4 = 1'b0;

        for (int i = 0; i < 5 && (q4.size() != 0 || q1.size() != 0); i++)
            @(negedge clk);
        check("drain_q4", q4.size(), 0);
        check("drain_q1", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
